// File: rtl/sc_seq_alu.sv
// Multi-cycle integer ALU feeding the processor status register.
// Logic/add/sub finish in one cycle, shifts go one bit per cycle, and UMUL uses shift-add.
module sc_seq_alu #(
    parameter int DATAWIDTH_BUS           = 32,
    parameter int DATAWIDTH_ALU_SELECTION = 4
) (
    input  logic                               SC_SeqAlu_CLOCK_50,
    input  logic                               SC_SeqAlu_RESET_InHigh,
    input  logic                               SC_SeqAlu_Start_InHigh,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0] SC_SeqAlu_Selection,
    input  logic [DATAWIDTH_BUS-1:0]           SC_SeqAlu_DataA,
    input  logic [DATAWIDTH_BUS-1:0]           SC_SeqAlu_DataB,
    output logic [DATAWIDTH_BUS-1:0]           SC_SeqAlu_Result,
    output logic                               SC_SeqAlu_Busy,
    output logic                               SC_SeqAlu_Done,
    output logic                               SC_SeqAlu_negativo,
    output logic                               SC_SeqAlu_cero,
    output logic                               SC_SeqAlu_overflow,
    output logic                               SC_SeqAlu_carry,
    output logic                               SC_SeqAlu_PsrWrite_InLow
);
    localparam int W    = DATAWIDTH_BUS;
    localparam int SHW  = $clog2(W);
    localparam int CNTW = SHW + 1;

    typedef logic [DATAWIDTH_ALU_SELECTION-1:0] op_t;
    localparam op_t OP_ADD    = op_t'(0);
    localparam op_t OP_ADDCC  = op_t'(1);
    localparam op_t OP_SUB    = op_t'(2);
    localparam op_t OP_SUBCC  = op_t'(3);
    localparam op_t OP_AND    = op_t'(4);
    localparam op_t OP_ANDCC  = op_t'(5);
    localparam op_t OP_OR     = op_t'(6);
    localparam op_t OP_ORCC   = op_t'(7);
    localparam op_t OP_XOR    = op_t'(8);
    localparam op_t OP_XORCC  = op_t'(9);
    localparam op_t OP_SLL    = op_t'(10);
    localparam op_t OP_SRL    = op_t'(11);
    localparam op_t OP_SRA    = op_t'(12);
    localparam op_t OP_UMUL   = op_t'(13);
    localparam op_t OP_UMULCC = op_t'(14);

    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

    state_t         state_r, state_n;
    op_t            op_r, op_n;
    logic [W-1:0]   work_r, work_n;   // shift operand, or shifted multiplicand
    logic [W-1:0]   mb_r, mb_n;       // multiplier, consumed LSB first
    logic [W-1:0]   acc_r, acc_n;
    logic [CNTW-1:0] cnt_r, cnt_n;
    logic [W-1:0]   result_r;
    logic           n_r, z_r, v_r, c_r, done_r, psrw_r;

    logic           fin, fin_cc, fin_v, fin_c;
    logic [W-1:0]   fin_res, sh, acc_add;
    logic [W:0]     sum, diff;

    function automatic logic is_cc(input op_t o);
        return (o == OP_ADDCC) || (o == OP_SUBCC) || (o == OP_ANDCC) ||
               (o == OP_ORCC)  || (o == OP_XORCC) || (o == OP_UMULCC);
    endfunction

    assign sum     = {1'b0, SC_SeqAlu_DataA} + {1'b0, SC_SeqAlu_DataB};
    assign diff    = {1'b0, SC_SeqAlu_DataA} - {1'b0, SC_SeqAlu_DataB};
    assign acc_add = acc_r + (mb_r[0] ? work_r : '0);

    always_comb begin
        case (op_r)
            OP_SLL:  sh = {work_r[W-2:0], 1'b0};
            OP_SRA:  sh = {work_r[W-1], work_r[W-1:1]};
            default: sh = {1'b0, work_r[W-1:1]};
        endcase
    end

    always_comb begin
        state_n = state_r;
        op_n    = op_r;
        work_n  = work_r;
        mb_n    = mb_r;
        acc_n   = acc_r;
        cnt_n   = cnt_r;
        fin     = 1'b0;
        fin_res = '0;
        fin_v   = 1'b0;
        fin_c   = 1'b0;
        unique case (state_r)
            IDLE: if (SC_SeqAlu_Start_InHigh) begin
                op_n = SC_SeqAlu_Selection;
                case (SC_SeqAlu_Selection)
                    OP_ADD, OP_ADDCC: begin
                        fin     = 1'b1;
                        fin_res = sum[W-1:0];
                        fin_v   = (SC_SeqAlu_DataA[W-1] == SC_SeqAlu_DataB[W-1]) &&
                                  (sum[W-1] != SC_SeqAlu_DataA[W-1]);
                        fin_c   = sum[W];
                    end
                    OP_SUB, OP_SUBCC: begin
                        fin     = 1'b1;
                        fin_res = diff[W-1:0];
                        fin_v   = (SC_SeqAlu_DataA[W-1] != SC_SeqAlu_DataB[W-1]) &&
                                  (diff[W-1] != SC_SeqAlu_DataA[W-1]);
                        fin_c   = diff[W];
                    end
                    OP_AND, OP_ANDCC: begin
                        fin     = 1'b1;
                        fin_res = SC_SeqAlu_DataA & SC_SeqAlu_DataB;
                    end
                    OP_OR, OP_ORCC: begin
                        fin     = 1'b1;
                        fin_res = SC_SeqAlu_DataA | SC_SeqAlu_DataB;
                    end
                    OP_XOR, OP_XORCC: begin
                        fin     = 1'b1;
                        fin_res = SC_SeqAlu_DataA ^ SC_SeqAlu_DataB;
                    end
                    OP_SLL, OP_SRL, OP_SRA: begin
                        if (SC_SeqAlu_DataB[SHW-1:0] == '0) begin
                            fin     = 1'b1;
                            fin_res = SC_SeqAlu_DataA;
                        end else begin
                            state_n = SHIFT;
                            work_n  = SC_SeqAlu_DataA;
                            cnt_n   = {1'b0, SC_SeqAlu_DataB[SHW-1:0]};
                        end
                    end
                    OP_UMUL, OP_UMULCC: begin
                        state_n = MUL;
                        work_n  = SC_SeqAlu_DataA;
                        mb_n    = SC_SeqAlu_DataB;
                        acc_n   = '0;
                        cnt_n   = CNTW'(W);
                    end
                    default: fin = 1'b1;   // reserved opcode: result 0
                endcase
            end
            SHIFT: begin
                work_n = sh;
                cnt_n  = cnt_r - 1'b1;
                if (cnt_r == CNTW'(1)) begin
                    fin     = 1'b1;
                    fin_res = sh;
                end
            end
            MUL: begin
                acc_n  = acc_add;
                work_n = {work_r[W-2:0], 1'b0};
                mb_n   = {1'b0, mb_r[W-1:1]};
                cnt_n  = cnt_r - 1'b1;
                if (cnt_r == CNTW'(1)) begin
                    fin     = 1'b1;
                    fin_res = acc_add;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (fin) state_n = DONE;
        fin_cc = fin && is_cc(op_n);
    end

    always_ff @(posedge SC_SeqAlu_CLOCK_50) begin
        if (SC_SeqAlu_RESET_InHigh) begin
            state_r  <= IDLE;
            op_r     <= '0;
            work_r   <= '0;
            mb_r     <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            result_r <= '0;
            n_r      <= 1'b0;
            z_r      <= 1'b0;
            v_r      <= 1'b0;
            c_r      <= 1'b0;
            done_r   <= 1'b0;
            psrw_r   <= 1'b1;
        end else begin
            state_r <= state_n;
            op_r    <= op_n;
            work_r  <= work_n;
            mb_r    <= mb_n;
            acc_r   <= acc_n;
            cnt_r   <= cnt_n;
            done_r  <= fin;
            psrw_r  <= !fin_cc;
            if (fin) result_r <= fin_res;
            if (fin_cc) begin
                n_r <= fin_res[W-1];
                z_r <= (fin_res == '0);
                v_r <= fin_v;
                c_r <= fin_c;
            end
        end
    end

    assign SC_SeqAlu_Result         = result_r;
    assign SC_SeqAlu_Busy           = (state_r != IDLE);
    assign SC_SeqAlu_Done           = done_r;
    assign SC_SeqAlu_negativo       = n_r;
    assign SC_SeqAlu_cero           = z_r;
    assign SC_SeqAlu_overflow       = v_r;
    assign SC_SeqAlu_carry          = c_r;
    assign SC_SeqAlu_PsrWrite_InLow = psrw_r;
endmodule

// File: tb/tb_sc_seq_alu.sv
// Directed bench for sc_seq_alu: latency, result, flags and strobe per operation.
module tb_sc_seq_alu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] da = '0, db = '0;
    logic [31:0] result;
    logic        busy, done, fn, fz, fv, fc, psrw;
    int          total = 0, bad = 0;

    sc_seq_alu dut (
        .SC_SeqAlu_CLOCK_50(clk), .SC_SeqAlu_RESET_InHigh(rst),
        .SC_SeqAlu_Start_InHigh(start), .SC_SeqAlu_Selection(sel),
        .SC_SeqAlu_DataA(da), .SC_SeqAlu_DataB(db),
        .SC_SeqAlu_Result(result), .SC_SeqAlu_Busy(busy), .SC_SeqAlu_Done(done),
        .SC_SeqAlu_negativo(fn), .SC_SeqAlu_cero(fz), .SC_SeqAlu_overflow(fv),
        .SC_SeqAlu_carry(fc), .SC_SeqAlu_PsrWrite_InLow(psrw)
    );

    always #10 clk = ~clk;

    // Issues one op and follows it to the cycle after Done; no comparisons here.
    task automatic run_op(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output logic [3:0] nzvc,
                          output int lows, output logic busy1, output logic post_busy);
        @(posedge clk); #1;
        start = 1'b1; sel = s; da = a; db = b;
        @(posedge clk); #1;
        start = 1'b0; da = ~a; db = ~b;
        lat = 1; lows = 0; busy1 = busy;
        if (!psrw) lows++;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (!psrw) lows++;
        end
        res = result; nzvc = {fn, fz, fv, fc};
        @(posedge clk); #1;
        if (!psrw) lows++;
        post_busy = busy;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({result, busy, done, fn, fz, fv, fc, psrw} !== {32'h0, 7'b0000001}) begin
            bad++;
            $display("FAIL reset: got res=%h busy=%b done=%b nzvc=%b%b%b%b psrw=%b, want 0/0/0/0000/1",
                     result, busy, done, fn, fz, fv, fc, psrw);
        end
        rst = 1'b0;
    endtask

    task automatic test_addcc;
        int lat, lows; logic [31:0] res; logic [3:0] f; logic b1, pb;
        run_op(4'h1, 32'h7FFFFFFF, 32'h00000001, lat, res, f, lows, b1, pb);
        total++;
        if ({lat, res, f, lows, b1, pb} !== {32'd1, 32'h80000000, 4'b1010, 32'd1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL addcc: got lat=%0d res=%h nzvc=%b lows=%0d busy1=%b post_busy=%b, want 1/80000000/1010/1/1/0",
                     lat, res, f, lows, b1, pb);
        end
    endtask

    task automatic test_sub;
        int lat, lows; logic [31:0] res; logic [3:0] f; logic b1, pb;
        run_op(4'h3, 32'h3, 32'h5, lat, res, f, lows, b1, pb);
        total++;
        if ({lat, res, f, lows} !== {32'd1, 32'hFFFFFFFE, 4'b1001, 32'd1}) begin
            bad++;
            $display("FAIL subcc: got lat=%0d res=%h nzvc=%b lows=%0d, want 1/fffffffe/1001/1", lat, res, f, lows);
        end
        run_op(4'h2, 32'h3, 32'h5, lat, res, f, lows, b1, pb);
        total++;
        if ({lat, res, f, lows} !== {32'd1, 32'hFFFFFFFE, 4'b1001, 32'd0}) begin
            bad++;
            $display("FAIL sub_plain: got lat=%0d res=%h nzvc=%b lows=%0d, want 1/fffffffe/1001/0", lat, res, f, lows);
        end
    endtask

    task automatic test_shift;
        int lat, lows; logic [31:0] res; logic [3:0] f; logic b1, pb;
        run_op(4'hC, 32'h80000000, 32'd4, lat, res, f, lows, b1, pb);
        total++;
        if ({lat, res, lows} !== {32'd5, 32'hF8000000, 32'd0}) begin
            bad++;
            $display("FAIL sra4: got lat=%0d res=%h lows=%0d, want 5/f8000000/0", lat, res, lows);
        end
        run_op(4'hA, 32'h12345678, 32'h0, lat, res, f, lows, b1, pb);
        total++;
        if ({lat, res} !== {32'd1, 32'h12345678}) begin
            bad++;
            $display("FAIL sll0: got lat=%0d res=%h, want 1/12345678", lat, res);
        end
        run_op(4'hB, 32'hFFFFFFFF, 32'd31, lat, res, f, lows, b1, pb);
        total++;
        if ({lat, res, f} !== {32'd32, 32'h00000001, 4'b1001}) begin
            bad++;
            $display("FAIL srl31: got lat=%0d res=%h nzvc=%b, want 32/00000001/1001", lat, res, f);
        end
        run_op(4'hA, 32'h00000003, 32'd3, lat, res, f, lows, b1, pb);
        total++;
        if ({lat, res} !== {32'd4, 32'h00000018}) begin
            bad++;
            $display("FAIL sll3: got lat=%0d res=%h, want 4/00000018", lat, res);
        end
    endtask

    task automatic test_mul;
        int lat, lows; logic [31:0] res; logic [3:0] f; logic b1, pb;
        run_op(4'hE, 32'h00010000, 32'h00010000, lat, res, f, lows, b1, pb);
        total++;
        if ({lat, res, f, lows} !== {32'd33, 32'h0, 4'b0100, 32'd1}) begin
            bad++;
            $display("FAIL umulcc: got lat=%0d res=%h nzvc=%b lows=%0d, want 33/00000000/0100/1", lat, res, f, lows);
        end
        run_op(4'hD, 32'd12345, 32'd678, lat, res, f, lows, b1, pb);
        total++;
        if ({lat, res, f, lows} !== {32'd33, 32'd8369910, 4'b0100, 32'd0}) begin
            bad++;
            $display("FAIL umul: got lat=%0d res=%0d nzvc=%b lows=%0d, want 33/8369910/0100/0", lat, res, f, lows);
        end
    endtask

    task automatic test_andcc;
        int lat, lows; logic [31:0] res; logic [3:0] f; logic b1, pb;
        run_op(4'h1, 32'hFFFFFFFF, 32'h00000002, lat, res, f, lows, b1, pb);  // sets C=1 first
        run_op(4'h5, 32'hF0F0F0F0, 32'h0F0F0F0F, lat, res, f, lows, b1, pb);
        total++;
        if ({lat, res, f, lows} !== {32'd1, 32'h0, 4'b0100, 32'd1}) begin
            bad++;
            $display("FAIL andcc: got lat=%0d res=%h nzvc=%b lows=%0d, want 1/00000000/0100/1", lat, res, f, lows);
        end
    endtask

    task automatic test_ignore;
        int dones = 0, done_at = 0;
        logic post_busy = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; sel = 4'hD; da = 32'd3; db = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin dones++; done_at = c; end
            if (c == done_at + 1 && done_at != 0) post_busy = busy;
            start = (c == 10) || (done && c == done_at);
            sel = 4'h0; da = 32'd100; db = 32'd200;
            @(posedge clk); #1;
        end
        start = 1'b0;
        total++;
        if ({dones, done_at, result, post_busy} !== {32'd1, 32'd33, 32'd15, 1'b0}) begin
            bad++;
            $display("FAIL ignore_start: got dones=%0d at=%0d res=%0d post_busy=%b, want 1/33/15/0",
                     dones, done_at, result, post_busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] pat = '0;
        @(posedge clk); #1;
        start = 1'b1; sel = 4'h0; da = 32'd1; db = 32'd2;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 5) start = 1'b0;
            pat[7-i] = done;
        end
        total++;
        if ({pat, result} !== {8'b10101000, 32'd3}) begin
            bad++;
            $display("FAIL back_to_back: got done pattern=%b res=%0d, want 10101000/3", pat, result);
        end
    endtask

    task automatic test_reset_abort;
        int dones = 0;
        @(posedge clk); #1;
        start = 1'b1; sel = 4'hD; da = 32'd7; db = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({result, busy, done, fn, fz, fv, fc, psrw} !== {32'h0, 7'b0000001}) begin
            bad++;
            $display("FAIL reset_abort: got res=%h busy=%b done=%b nzvc=%b%b%b%b psrw=%b, want 0/0/0/0000/1",
                     result, busy, done, fn, fz, fv, fc, psrw);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL reset_no_done: got dones=%0d, want 0", dones);
        end
    endtask

    task automatic test_reserved;
        int lat, lows; logic [31:0] res; logic [3:0] f; logic b1, pb;
        run_op(4'h0, 32'd5, 32'd6, lat, res, f, lows, b1, pb);
        total++;
        if ({lat, res, lows} !== {32'd1, 32'd11, 32'd0}) begin
            bad++;
            $display("FAIL add_plain: got lat=%0d res=%0d lows=%0d, want 1/11/0", lat, res, lows);
        end
        run_op(4'hF, 32'd5, 32'd6, lat, res, f, lows, b1, pb);
        total++;
        if ({lat, res, f, lows, b1} !== {32'd1, 32'd0, 4'b0000, 32'd0, 1'b1}) begin
            bad++;
            $display("FAIL reserved: got lat=%0d res=%0d nzvc=%b lows=%0d busy1=%b, want 1/0/0000/0/1",
                     lat, res, f, lows, b1);
        end
    endtask

    initial begin
        test_reset;
        test_addcc;
        test_sub;
        test_shift;
        test_mul;
        test_andcc;
        test_ignore;
        test_back_to_back;
        test_reset_abort;
        test_reserved;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
